// File: rtl/incdec_counter_nbit.sv
// Registered N-bit up/down step counter built on a ripple chain of inc/dec cells,
// with load, wrap/saturate policy, limit pulse and target-match stop.
module incdec_counter_nbit #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             id,
    input  logic             ld,
    input  logic [WIDTH-1:0] din,
    input  logic             sat,
    input  logic [WIDTH-1:0] tgt,
    input  logic             tgt_en,
    output logic [WIDTH-1:0] q,
    output logic             ovf,
    output logic             zero,
    output logic             done
);

    typedef enum logic {RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] step;
    logic             lim;

    // Each cell toggles on an incoming carry; it passes the carry on when its
    // bit is 1 (inc) or 0 (dec). A carry out of the MSB means a limit crossing.
    assign c[0] = 1'b1;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_cell
            assign step[i]  = q_q[i] ^ c[i];
            assign c[i+1]   = (id ? q_q[i] : ~q_q[i]) & c[i];
        end
    endgenerate

    assign lim = c[WIDTH];

    always_comb begin
        q_d     = q_q;
        ovf_d   = 1'b0;
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (ld) begin
                    q_d = din;
                    if (tgt_en && din == tgt) state_d = DONE;
                end else if (en) begin
                    ovf_d = lim;
                    q_d   = (lim && sat) ? q_q : step;
                    if (tgt_en && q_d == tgt) state_d = DONE;
                end
            end
            DONE: begin
                if (ld) begin
                    q_d     = din;
                    state_d = (tgt_en && din == tgt) ? DONE : RUN;
                end else if (!tgt_en) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        zero_d = (q_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q     <= RST_VAL;
            ovf_q   <= 1'b0;
            zero_q  <= (RST_VAL == '0);
            state_q <= RUN;
        end else begin
            q_q     <= q_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            state_q <= state_d;
        end
    end

    assign q    = q_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;
    assign done = (state_q == DONE);

endmodule

// File: doc/incdec_counter_nbit.md
Name: incdec_counter_nbit

Overview:
- Registered N-bit up/down counter that sits directly downstream of the team's 1-bit inc/dec cell.
- Its next-value datapath is a WIDTH-bit ripple chain of inc/dec cells, with a shared direction select and the carry/borrow propagated LSB to MSB.
- The chain result is captured in a count register on each enabled clock.
- Adds load, wrap/saturate policy, overflow/underflow pulse and a target-match stop state machine, used as a step/position counter feeding downstream compare logic.

Parameters:
- WIDTH, 4, counter width in bits (>=2).
- RST_VAL, 0, value of q after reset (WIDTH bits).

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable, one step per cycle while high.
- id  input  1  direction: 1 = increment, 0 = decrement.
- ld  input  1  synchronous load of din.
- din  input  WIDTH  load value.
- sat  input  1  1 = saturate at limits, 0 = wrap modulo 2^WIDTH.
- tgt  input  WIDTH  stop target.
- tgt_en  input  1  1 = stop counting when q reaches tgt.
- q  output  WIDTH  registered count.
- ovf  output  1  registered one-cycle pulse: increment attempted from all-ones or decrement attempted from zero.
- zero  output  1  registered, high when q == 0.
- done  output  1  high while the FSM is in DONE.

Behaviour:
- Synchronous reset: when rst is high at a clock edge, then q=RST_VAL, ovf=0, zero=(RST_VAL==0), done=0, FSM=RUN. All other inputs are ignored that cycle.
- Priority per edge: rst > ld > en. When ld and en are both high, the load wins and no step is taken.
- Datapath: next = q+1 (id=1) or q-1 (id=0).
  - Chain carry-out from the MSB cell = overflow on increment.
  - Borrow (no carry-out) on decrement = underflow.
  - Arithmetic is modulo 2^WIDTH before the saturation rule is applied.
- FSM states: RUN, DONE.
  - RUN, ld=1: q<=din. If tgt_en=1 and din==tgt, go to DONE, else stay in RUN.
  - RUN, en=1, ld=0: q<=stepped value (subject to sat). If tgt_en=1 and the new q==tgt, go to DONE.
  - RUN, en=0, ld=0: hold q.
  - DONE: q holds regardless of en. ld=1 loads din and returns to RUN, unless din==tgt with tgt_en=1, in which case it stays in DONE. Deasserting tgt_en returns to RUN next cycle with q held.
  - done is registered and equals (state==DONE).
  - No step is taken in the cycle the FSM enters RUN from DONE; counting resumes the following cycle.
- ovf: set to 1 for exactly one cycle following any enabled step in RUN that crosses a limit (inc from 2^WIDTH-1, dec from 0), otherwise 0. A load never asserts ovf.
  - sat=0: q wraps (all-ones -> 0, 0 -> all-ones) and ovf pulses.
  - sat=1: q holds at the limit and ovf still pulses on every attempted crossing.
- zero: registered, updated every cycle from the next value of q. It therefore coincides with q, with no extra cycle of lag.
- Latency: q reflects en/ld/din one clock after the sampling edge. The target match is evaluated on the new value, so done rises in the same cycle as q==tgt.
- Target start case: tgt_en=1 with q already == tgt while in RUN and no step, e.g. after reset with RST_VAL==tgt. The FSM does not move to DONE; only a load or a step that lands on tgt enters DONE.
- Changing id mid-count takes effect on the next enabled edge, with no pipeline bubble.
- Reset asserted mid-count or in DONE overrides everything within one edge.

Test Plan:
- Reset: WIDTH=4, drive rst=1 for 2 cycles with en=1, id=1 -> q=0, zero=1, ovf=0, done=0. Release rst -> q counts 1,2,3 on successive edges.
- Wrap up: ld din=4'hE, then en=1, id=1, sat=0 for 3 cycles -> q=F, 0, 1. ovf=1 only in the cycle q=0. zero=1 in that same cycle.
- Saturate down: ld din=1, en=1, id=0, sat=1 for 3 cycles -> q=0, 0, 0. ovf=0, then 1, then 1. zero=1 from the first step.
- Load priority: q=5, then ld=1 din=9 together with en=1, id=1 -> q=9, not 6 or 10. ovf=0.
- Target stop: tgt=7, tgt_en=1, from q=4 with en=1, id=1 -> q=5, 6, 7, then holds at 7. done=1 from the cycle q=7. Then ld din=2 -> q=2, done=0, counting resumes.
- Reset in DONE: in DONE with q=7, assert rst -> q=0, done=0, ovf=0 next edge. Release rst -> counting resumes from 0.
